uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- UART 8N1 transmitter with an input FIFO. It is the transmit-side counterpart to the bluetooth receive path.
- It lets control logic send telemetry bytes (status, echoed commands) back to the phone over the HC-05 module's RX pin.
- Bytes are pushed into the FIFO on a single-cycle write strobe. Frames are serialized back-to-back at the configured baud rate.
- It sits beside the bluetooth receiver in the Shark top level and shares clk and the reset source.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ / BAUD, integer-truncated (10416 at the defaults). CLKS_PER_BIT must be ≥ 2.
- FIFO_DEPTH, 8, FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe. One byte is written per cycle in which wr_en=1 and full=0.
- wr_data  in  8  byte to enqueue.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag. Set when wr_en=1 while full=1. Cleared only by reset.
- tx  out  1  serial output, idle high.
- busy  out  1  high whenever a frame is in progress (state != IDLE).
- frame_done  out  1  single-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, busy=0, frame_done=0, overflow=0.
  - FIFO is flushed: count=0, empty=1, full=0.
  - state=IDLE, baud counter=0, bit index=0.
  - A partial frame is abandoned. tx is high from the reset edge on.
- Outputs: all outputs are registered or decoded from registered state; there are no combinational paths from the inputs.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits. Pointers wrap from FIFO_DEPTH-1 to 0.
  - full, empty and count are derived from registered occupancy.
  - A write is accepted iff wr_en=1 and full=0 in that cycle. A write while full is dropped, the FIFO is unchanged, and overflow is set.
  - When a pop and an accepted write occur in the same cycle, count is unchanged. This holds at any occupancy, including full (the write is rejected if full=1 that cycle, even when a pop coincides).
- State machine: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If empty=0, then at the next edge: pop the head byte into the shift register, enter START, set tx<=0, clear the baud counter.
    - A byte written into an empty FIFO at edge E0 gives tx falling at edge E1 (one cycle of latency).
  - START:
    - tx=0 for exactly CLKS_PER_BIT cycles.
    - Then enter DATA with bit index 0, and drive tx with data bit 0.
  - DATA:
    - Bits are sent LSB first. Each bit is held for exactly CLKS_PER_BIT cycles.
    - After bit 7 completes, enter STOP with tx=1.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - On the final cycle, frame_done=1.
    - At the next edge: if empty=0, pop and enter START directly, with no idle gap between frames. Otherwise enter IDLE.
- Frame timing: every frame is exactly 10*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs when the counter reaches CLKS_PER_BIT-1.
- Byte latching: the popped byte is latched into the shift register at pop time. Later FIFO writes never disturb the frame in flight.
- busy: 1 from the pop edge through the last STOP cycle. busy stays 1 continuously across back-to-back frames.

Test Plan:
(Bench uses CLK_FREQ=1000, BAUD=100, giving CLKS_PER_BIT=10.)
- Reset check: assert reset mid-frame (cycle 35 of a frame) -> tx=1, busy=0, count=0, empty=1 immediately. No further tx edges until the next write.
- Single byte:
  - Stimulus: write 8'hA5 to an idle, empty block.
  - tx falls 1 cycle after the write edge.
  - Line pattern: 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles.
  - frame_done pulses at cycle 99 of the frame; busy drops the following cycle.
- Back-to-back:
  - Stimulus: write 8'h55, 8'h0F, 8'hFF on consecutive cycles.
  - Three frames of 100 cycles each, the second start bit immediately following the first stop bit.
  - busy is held 1 for 300 cycles; frame_done pulses 3 times.
- Full/overflow:
  - Stimulus: write 9 bytes in 9 consecutive cycles with FIFO_DEPTH=8, starting from idle.
  - The first byte pops at cycle 1, so the FIFO fills to 8 with all 9 bytes accepted and overflow=0.
  - A 10th write while full=1 is dropped and sets overflow=1.
  - Transmitted sequence equals the first 9 bytes in order.
- Simultaneous push/pop:
  - Stimulus: with count=3 in STOP, write on the same edge as the pop.
  - count stays 3 and byte order is preserved.
  - Pointer wrap is exercised by sending 20 bytes through depth 8; the output order must match the input order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a circular byte FIFO. A queued byte starts a frame one cycle after it is written,
// and queued bytes then go out back-to-back. All outputs come from registers or are decoded from registered state.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST    = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRELAST = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] DEPTH        = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q, frame_done_q;

  logic push, pop;

  assign full       = (count_q == DEPTH);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // A pop happens either from IDLE or on the last stop-bit cycle, so frames chain without a gap.
  assign push    = wr_en && !full;
  assign pop     = !empty && ((state_q == IDLE) ||
                              ((state_q == STOP) && (baud_q == BAUD_LAST)));
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse lands on the final stop cycle.
          if (baud_q == BAUD_PRELAST) frame_done_q <= 1'b1;
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit; checks line levels cycle by cycle against each byte.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx, busy, frame_done;
  logic [3:0] count;

  int tests = 0;
  int failed = 0;
  int fd_seen = 0;
  int fd_base;

  logic [7:0] ov [10] = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h00, 8'h99, 8'h12, 8'hE7, 8'h5A, 8'hAA};
  logic [7:0] sp [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] wd [20];

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the falling clock edge of frame cycle 'first' (cycle 0 = first start-bit cycle).
  // Optionally presents one write during frame cycle wr_at. Returns at frame cycle 100.
  task automatic expect_frame(input logic [7:0] b, input int first, input int wr_at,
                              input logic [7:0] wb);
    logic [9:0] line;
    line = {1'b1, b, 1'b0};
    for (int c = first; c < 100; c++) begin
      check($sformatf("tx byte=%h cyc=%0d", b, c), tx, line[c/10]);
      check($sformatf("busy byte=%h cyc=%0d", b, c), busy, 1'b1);
      check($sformatf("frame_done byte=%h cyc=%0d", b, c), frame_done, (c == 99));
      if (frame_done) fd_seen++;
      wr_en   = (c == wr_at);
      wr_data = wb;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) wd[i] = 8'(i * 29 + 7);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst tx", tx, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst count", count, 4'd0);
    check("rst empty", empty, 1'b1);
    check("rst full", full, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst frame_done", frame_done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte A5: line 0,1,0,1,0,0,1,0,1,1
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    check("single count after write", count, 4'd1);
    check("single tx before fall", tx, 1'b1);
    @(negedge clk);
    expect_frame(8'hA5, 0, -1, 8'h00);
    check("single busy after frame", busy, 1'b0);
    check("single tx idle", tx, 1'b1);
    check("single empty", empty, 1'b1);

    // Back-to-back 55, 0F, FF
    fd_base = fd_seen;
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_data = 8'h0F;
    check("b2b tx before fall", tx, 1'b1);
    @(negedge clk);
    wr_data = 8'hFF;
    check("b2b count cyc0", count, 4'd1);
    check("b2b tx cyc0", tx, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    check("b2b count cyc1", count, 4'd2);
    expect_frame(8'h55, 1, -1, 8'h00);
    expect_frame(8'h0F, 0, -1, 8'h00);
    expect_frame(8'hFF, 0, -1, 8'h00);
    check("b2b frame_done pulses", fd_seen - fd_base, 3);
    check("b2b busy after", busy, 1'b0);
    check("b2b tx after", tx, 1'b1);

    // Fill to full with 9 writes, 10th dropped
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; wr_data = ov[k];
      @(negedge clk);
      if (k >= 1) check($sformatf("ovf tx cyc=%0d", k - 1), tx, 1'b0);
      if (k == 8) begin
        check("ovf count at 9 writes", count, 4'd8);
        check("ovf full at 9 writes", full, 1'b1);
        check("ovf flag before 10th", overflow, 1'b0);
      end
    end
    wr_en = 1'b0;
    check("ovf flag after 10th", overflow, 1'b1);
    check("ovf count after 10th", count, 4'd8);
    expect_frame(ov[0], 8, -1, 8'h00);
    for (int k = 1; k < 9; k++) expect_frame(ov[k], 0, -1, 8'h00);
    check("ovf drained empty", empty, 1'b1);
    check("ovf tx idle", tx, 1'b1);
    check("ovf sticky", overflow, 1'b1);

    // Write on the same edge as the STOP pop with count=3
    wr_en = 1'b1; wr_data = sp[0];
    @(negedge clk);
    wr_data = sp[1];
    @(negedge clk);
    check("pp tx cyc0", tx, 1'b0);
    wr_data = sp[2];
    @(negedge clk);
    wr_data = sp[3];
    @(negedge clk);
    wr_en = 1'b0;
    check("pp count before", count, 4'd3);
    expect_frame(sp[0], 2, 99, sp[4]);
    check("pp count after push+pop", count, 4'd3);
    for (int k = 1; k < 5; k++) expect_frame(sp[k], 0, -1, 8'h00);
    check("pp empty", empty, 1'b1);

    // 20 bytes through depth 8, refilling one byte per frame
    for (int k = 0; k < 9; k++) begin
      wr_en = 1'b1; wr_data = wd[k];
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("wrap count full", count, 4'd8);
    expect_frame(wd[0], 7, -1, 8'h00);
    for (int i = 1; i < 20; i++)
      expect_frame(wd[i], 0, (i <= 11) ? 50 : -1, (i + 8 < 20) ? wd[i + 8] : 8'h00);
    check("wrap empty", empty, 1'b1);
    check("wrap busy", busy, 1'b0);

    // Reset mid-frame at frame cycle 35
    wr_en = 1'b1; wr_data = 8'hF0;
    @(negedge clk);
    wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    for (int c = 0; c < 35; c++) @(negedge clk);
    check("mid tx before reset", tx, 1'b0);
    check("mid count before reset", count, 4'd1);
    reset = 1'b1;
    #1;
    check("mid rst tx", tx, 1'b1);
    check("mid rst busy", busy, 1'b0);
    check("mid rst count", count, 4'd0);
    check("mid rst empty", empty, 1'b1);
    check("mid rst overflow", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      check($sformatf("post-rst tx quiet cyc=%0d", c), tx, 1'b1);
      check($sformatf("post-rst busy cyc=%0d", c), busy, 1'b0);
    end
    wr_en = 1'b1; wr_data = 8'h96;
    @(negedge clk);
    wr_en = 1'b0;
    check("post-rst count", count, 4'd1);
    @(negedge clk);
    expect_frame(8'h96, 0, -1, 8'h00);
    check("post-rst idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
